rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
Two-master arbiter sharing the single-port program ROM between master 0 (instruction fetch) and master 1 (loader/debug reader). It grants ownership round-robin and sequences each ROM access as a one-cycle cs_/as_ strobe. It forwards the ROM's rdy_ and read data to the owning master. A per-grant burst limit prevents one master from holding the ROM while the other waits.

Parameters:
ADDR_W, 11, ROM word-address width (matches RomAddrBus)
DATA_W, 32, word data width (matches WordDataBus)
MAX_BURST, 8, accesses allowed per grant while the other master requests; range 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
m0_req_  in  1  master 0 bus request, active-low
m0_as_  in  1  master 0 address strobe, active-low
m0_addr  in  ADDR_W  master 0 address
m0_grnt_  out  1  master 0 grant, active-low
m0_rdy_  out  1  master 0 ready, active-low
m0_rd_data  out  DATA_W  master 0 read data
m1_req_, m1_as_, m1_addr, m1_grnt_, m1_rdy_, m1_rd_data  same as master 0, for master 1
rom_cs_  out  1  ROM chip select, active-low
rom_as_  out  1  ROM address strobe, active-low
rom_addr  out  ADDR_W  ROM address (registered)
rom_rd_data  in  DATA_W  ROM read data
rom_rdy_  in  1  ROM ready, active-low

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - state=IDLE; grnt_, rdy_, rom_cs_, rom_as_ all 1; rom_addr=0; burst count=0.
  - last_owner=M1, so M0 wins the first tie.
  - Reset mid-access aborts it; a late rom_rdy_ is not forwarded.
- States: IDLE, GRANTED, ISSUE, WAIT.
- IDLE:
  - No grants.
  - Sample requests; if exactly one req_=0, that master becomes owner.
  - If both, the master other than last_owner becomes owner.
  - Next state GRANTED. Grant is registered: owner's grnt_=0 from the cycle after the request is sampled.
- GRANTED:
  - If owner req_=1: clear grant, last_owner=owner, burst count=0, go to IDLE.
  - Else if burst count==MAX_BURST and other master's req_=0: revoke grant the same way (forced release), go to IDLE. The other master wins the next arbitration through round-robin.
  - Else if owner as_=0: register owner addr into rom_addr, drive rom_cs_=rom_as_=0 next cycle, go to ISSUE.
  - Non-owner as_ is ignored in all states.
- ISSUE:
  - Strobes are low for exactly this one cycle.
  - Increment burst count (saturates at MAX_BURST).
  - Go to WAIT; strobes return to 1.
- WAIT:
  - While rom_rdy_=1, stay.
  - When rom_rdy_=0: owner rdy_=0 and owner rd_data=rom_rd_data combinationally in that cycle; go to GRANTED.
- Latency: owner as_ sampled at edge t → strobes visible t+1 → rdy_/data visible t+2. Back-to-back accesses therefore issue every 3 cycles.
- Owner as_ during ISSUE/WAIT is ignored. The master must hold its request until rdy_ before strobing again.
- Owner deasserting req_ during ISSUE/WAIT is honoured only on return to GRANTED; the access always completes.
- Non-owner rdy_=1; non-owner rd_data=0.
- Burst count resets to 0 on every grant change. The limit applies only when the other master is requesting.

Decomposition:
- Shared package/header:
  - state encoding (2-bit: IDLE=0, GRANTED=1, ISSUE=2, WAIT=3)
  - owner encoding (OWNER_M0=0, OWNER_M1=1)
  - the existing ENABLE_/DISABLE_ strobe constants
- Natural sub-module: rom_arb_rr. It holds the last_owner flop and combinational 2-way round-robin selection, and is reused by later shared-memory arbiters.

Test Plan:
- Only M0 requests at addr 0x010, ROM returns 0xDEADBEEF → m0_grnt_ low 1 cycle after req; rom_cs_/as_ low exactly 1 cycle with rom_addr=0x010; m0_rdy_ low with data 0xDEADBEEF 2 cycles after m0_as_.
- M0 and M1 request in the same cycle after reset → M0 granted first. After M0 releases, M1 is granted; a following simultaneous request grants M0 again (alternation).
- M0 holds grant issuing continuous reads while M1 requests, MAX_BURST=8 → after the 8th completed access m0_grnt_ goes high, M1 granted 1 cycle later; M0 receives no 9th strobe.
- Non-owner M1 pulses m1_as_ during M0 ownership → no ROM strobe, m1_rdy_ stays 1.
- ROM delays rom_rdy_ by 3 extra cycles → FSM holds WAIT, owner rdy_ stays 1 until rom_rdy_=0, then single-cycle rdy_.
- Reset asserted in WAIT → next cycle all strobes/grants 1, state IDLE; a subsequent rom_rdy_=0 produces no master rdy_.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared encodings for the program-ROM arbiter and later shared-memory arbiters.
// Holds the FSM state and owner encodings and the active-low strobe levels.
`timescale 1ns/1ps
package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ISSUE   = 2'd2,
        WAIT    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BURST_W = 8;

    function automatic owner_t other_owner(input owner_t o);
        if (o == OWNER_M0) begin
            return OWNER_M1;
        end else begin
            return OWNER_M0;
        end
    endfunction

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin selector: remembers the last owner and, on a tie,
// picks the other master. req is active-high here.
`timescale 1ns/1ps
module rom_arb_rr
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  owner_t     owner,
    output owner_t     sel
);

    owner_t last_owner;

    // last_owner starts at M1 so M0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWNER_M1;
        end else if (update) begin
            last_owner <= owner;
        end else begin
            last_owner <= last_owner;
        end
    end

    // selection: single requester wins, tie goes to the non-last owner
    always_comb begin
        sel = OWNER_M0;
        case (req)
            2'b01:   sel = OWNER_M0;
            2'b10:   sel = OWNER_M1;
            2'b11:   sel = other_owner(last_owner);
            default: sel = OWNER_M0;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-master arbiter for the single-port program ROM: round-robin grants,
// one-cycle cs_/as_ strobe per access, burst limit when the other master waits.
`timescale 1ns/1ps
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_,
    input  logic              m0_as_,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_grnt_,
    output logic              m0_rdy_,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req_,
    input  logic              m1_as_,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_grnt_,
    output logic              m1_rdy_,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              rom_cs_,
    output logic              rom_as_,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    input  logic              rom_rdy_
);

    arb_state_t           state;
    owner_t               owner;
    owner_t               next_owner;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 own_req;
    logic                 own_as;
    logic [ADDR_W-1:0]    own_addr;
    logic                 other_req;
    logic                 at_limit;
    logic                 release_grant;
    logic [1:0]           req_vec;

    // owner-relative views of the master inputs and the release decision
    always_comb begin
        req_vec = {m1_req_ == ENABLE_, m0_req_ == ENABLE_};
        if (owner == OWNER_M0) begin
            own_req   = (m0_req_ == ENABLE_);
            own_as    = (m0_as_  == ENABLE_);
            own_addr  = m0_addr;
            other_req = (m1_req_ == ENABLE_);
        end else begin
            own_req   = (m1_req_ == ENABLE_);
            own_as    = (m1_as_  == ENABLE_);
            own_addr  = m1_addr;
            other_req = (m0_req_ == ENABLE_);
        end
        at_limit      = (burst_cnt == BURST_W'(MAX_BURST));
        release_grant = (state == GRANTED) && (!own_req || (at_limit && other_req));
    end

    rom_arb_rr u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_vec),
        .update (release_grant),
        .owner  (owner),
        .sel    (next_owner)
    );

    // arbitration and access sequencing FSM with registered grants/strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWNER_M0;
            m0_grnt_  <= DISABLE_;
            m1_grnt_  <= DISABLE_;
            rom_cs_   <= DISABLE_;
            rom_as_   <= DISABLE_;
            rom_addr  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vec != 2'b00) begin
                        owner    <= next_owner;
                        m0_grnt_ <= (next_owner == OWNER_M0) ? ENABLE_ : DISABLE_;
                        m1_grnt_ <= (next_owner == OWNER_M1) ? ENABLE_ : DISABLE_;
                        state    <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (release_grant) begin
                        m0_grnt_  <= DISABLE_;
                        m1_grnt_  <= DISABLE_;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end else if (own_as) begin
                        rom_addr <= own_addr;
                        rom_cs_  <= ENABLE_;
                        rom_as_  <= ENABLE_;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    rom_cs_ <= DISABLE_;
                    rom_as_ <= DISABLE_;
                    if (!at_limit) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (rom_rdy_ == ENABLE_) begin
                        state <= GRANTED;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ROM ready and data pass straight through to the owner while waiting
    always_comb begin
        m0_rdy_    = DISABLE_;
        m1_rdy_    = DISABLE_;
        m0_rd_data = '0;
        m1_rd_data = '0;
        if (state == WAIT && rom_rdy_ == ENABLE_) begin
            if (owner == OWNER_M0) begin
                m0_rdy_    = ENABLE_;
                m0_rd_data = rom_rd_data;
            end else begin
                m1_rdy_    = ENABLE_;
                m1_rd_data = rom_rd_data;
            end
        end else begin
            m0_rdy_ = DISABLE_;
            m1_rdy_ = DISABLE_;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter: grants, strobes, round-robin,
// burst limit, non-owner strobes, slow ROM and reset during an access.
`timescale 1ns/1ps
module tb_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req_, m0_as_, m0_grnt_, m0_rdy_;
    logic [10:0] m0_addr;
    logic [31:0] m0_rd_data;
    logic        m1_req_, m1_as_, m1_grnt_, m1_rdy_;
    logic [10:0] m1_addr;
    logic [31:0] m1_rd_data;
    logic        rom_cs_, rom_as_, rom_rdy_;
    logic [10:0] rom_addr;
    logic [31:0] rom_rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    rom_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req_(m0_req_), .m0_as_(m0_as_), .m0_addr(m0_addr),
        .m0_grnt_(m0_grnt_), .m0_rdy_(m0_rdy_), .m0_rd_data(m0_rd_data),
        .m1_req_(m1_req_), .m1_as_(m1_as_), .m1_addr(m1_addr),
        .m1_grnt_(m1_grnt_), .m1_rdy_(m1_rdy_), .m1_rd_data(m1_rd_data),
        .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
        .rom_rd_data(rom_rd_data), .rom_rdy_(rom_rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_ = 1'b1; m0_as_ = 1'b1; m0_addr = 11'h000;
        m1_req_ = 1'b1; m1_as_ = 1'b1; m1_addr = 11'h000;
        rom_rdy_ = 1'b1; rom_rd_data = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_cmp++;
        if ({m0_grnt_, m1_grnt_, m0_rdy_, m1_rdy_, rom_cs_, rom_as_} !== 6'b111111) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b expected 111111",
                     {m0_grnt_, m1_grnt_, m0_rdy_, m1_rdy_, rom_cs_, rom_as_});
        end
        n_cmp++;
        if (rom_addr !== 11'h000 || m0_rd_data !== 32'h0 || m1_rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr %h d0 %h d1 %h expected zeros", rom_addr, m0_rd_data, m1_rd_data);
        end
    endtask

    // one owner access starting in GRANTED; extra = ROM wait cycles
    task automatic access(input int m, input logic [10:0] a, input logic [31:0] d, input int extra);
        logic own_rdy, oth_rdy;
        logic [31:0] own_data;
        if (m == 0) begin m0_as_ = 1'b0; m0_addr = a; end
        else begin m1_as_ = 1'b0; m1_addr = a; end
        tick();
        if (m == 0) m0_as_ = 1'b1; else m1_as_ = 1'b1;
        n_cmp++;
        if (rom_cs_ !== 1'b0 || rom_as_ !== 1'b0 || rom_addr !== a) begin
            n_bad++;
            $display("FAIL strobe_m%0d: cs %b as %b addr %h expected 0 0 %h", m, rom_cs_, rom_as_, rom_addr, a);
        end
        tick();
        for (int i = 0; i < extra; i++) begin
            own_rdy = (m == 0) ? m0_rdy_ : m1_rdy_;
            n_cmp++;
            if (own_rdy !== 1'b1 || rom_cs_ !== 1'b1) begin
                n_bad++;
                $display("FAIL wait_hold_m%0d: rdy %b cs %b expected 1 1", m, own_rdy, rom_cs_);
            end
            tick();
        end
        rom_rdy_ = 1'b0; rom_rd_data = d;
        #1;
        own_rdy  = (m == 0) ? m0_rdy_ : m1_rdy_;
        oth_rdy  = (m == 0) ? m1_rdy_ : m0_rdy_;
        own_data = (m == 0) ? m0_rd_data : m1_rd_data;
        n_cmp++;
        if (own_rdy !== 1'b0 || oth_rdy !== 1'b1 || own_data !== d || rom_cs_ !== 1'b1 || rom_as_ !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_m%0d: rdy %b other %b data %h cs %b expected 0 1 %h 1", m, own_rdy, oth_rdy, own_data, rom_cs_, d);
        end
        tick();
        rom_rdy_ = 1'b1;
        own_rdy = (m == 0) ? m0_rdy_ : m1_rdy_;
        n_cmp++;
        if (own_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_single_m%0d: rdy %b expected 1", m, own_rdy);
        end
    endtask

    task automatic test_single_m0();
        m0_req_ = 1'b0;
        tick();
        n_cmp++;
        if (m0_grnt_ !== 1'b0 || m1_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: g0 %b g1 %b expected 0 1", m0_grnt_, m1_grnt_);
        end
        access(0, 11'h010, 32'hDEADBEEF, 0);
        m0_req_ = 1'b1;
        tick();
        n_cmp++;
        if (m0_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL single_release: g0 %b expected 1", m0_grnt_);
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        m0_req_ = 1'b0; m1_req_ = 1'b0;
        tick();
        n_cmp++;
        if (m0_grnt_ !== 1'b0 || m1_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_first: g0 %b g1 %b expected 0 1", m0_grnt_, m1_grnt_);
        end
        access(0, 11'h123, 32'h0BADF00D, 0);
        m0_req_ = 1'b1;
        tick();
        n_cmp++;
        if (m0_grnt_ !== 1'b1 || m1_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_gap: g0 %b g1 %b expected 1 1", m0_grnt_, m1_grnt_);
        end
        tick();
        n_cmp++;
        if (m1_grnt_ !== 1'b0 || m0_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_second: g0 %b g1 %b expected 1 0", m0_grnt_, m1_grnt_);
        end
        access(1, 11'h7FF, 32'h12345678, 0);
        m1_req_ = 1'b1;
        tick();
        m0_req_ = 1'b0; m1_req_ = 1'b0;
        tick();
        n_cmp++;
        if (m0_grnt_ !== 1'b0 || m1_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_alternate: g0 %b g1 %b expected 0 1", m0_grnt_, m1_grnt_);
        end
        m0_req_ = 1'b1; m1_req_ = 1'b1;
        tick();
    endtask

    task automatic test_burst_limit();
        logic [10:0] a;
        m0_req_ = 1'b0;
        tick();
        m1_req_ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (m0_grnt_ !== 1'b0) begin
                n_bad++;
                $display("FAIL burst_hold_%0d: g0 %b expected 0", i, m0_grnt_);
            end
            a = 11'h200 + 11'(i);
            access(0, a, 32'hA5A50000 + 32'(i), 0);
        end
        m0_as_ = 1'b0;
        tick();
        n_cmp++;
        if (m0_grnt_ !== 1'b1 || rom_cs_ !== 1'b1) begin
            n_bad++;
            $display("FAIL burst_revoke: g0 %b cs %b expected 1 1", m0_grnt_, rom_cs_);
        end
        tick();
        m0_as_ = 1'b1;
        n_cmp++;
        if (m1_grnt_ !== 1'b0 || m0_grnt_ !== 1'b1 || rom_cs_ !== 1'b1) begin
            n_bad++;
            $display("FAIL burst_handover: g0 %b g1 %b cs %b expected 1 0 1", m0_grnt_, m1_grnt_, rom_cs_);
        end
        access(1, 11'h0F0, 32'h5A5A5A5A, 0);
        m0_req_ = 1'b1; m1_req_ = 1'b1;
        tick();
    endtask

    task automatic test_nonowner_as();
        m0_req_ = 1'b0;
        tick();
        m1_as_ = 1'b0; m1_addr = 11'h055;
        tick();
        n_cmp++;
        if (rom_cs_ !== 1'b1 || m1_rdy_ !== 1'b1 || m0_grnt_ !== 1'b0) begin
            n_bad++;
            $display("FAIL nonowner_as: cs %b rdy1 %b g0 %b expected 1 1 0", rom_cs_, m1_rdy_, m0_grnt_);
        end
        access(0, 11'h0AA, 32'h01020304, 0);
        m1_as_ = 1'b1;
    endtask

    task automatic test_slow_rom();
        access(0, 11'h3AA, 32'hCAFEF00D, 3);
        m0_req_ = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_wait();
        m0_req_ = 1'b0;
        tick();
        m0_as_ = 1'b0; m0_addr = 11'h444;
        tick();
        m0_as_ = 1'b1;
        tick();
        reset = 1'b1;
        m0_req_ = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({m0_grnt_, m1_grnt_, rom_cs_, rom_as_} !== 4'b1111 || rom_addr !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_wait: ctl %b addr %h expected 1111 000",
                     {m0_grnt_, m1_grnt_, rom_cs_, rom_as_}, rom_addr);
        end
        rom_rdy_ = 1'b0; rom_rd_data = 32'hFFFFFFFF;
        #1;
        n_cmp++;
        if (m0_rdy_ !== 1'b1 || m1_rdy_ !== 1'b1 || m0_rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL late_rdy: rdy0 %b rdy1 %b d0 %h expected 1 1 0", m0_rdy_, m1_rdy_, m0_rd_data);
        end
        tick();
        n_cmp++;
        if (m0_rdy_ !== 1'b1 || m0_grnt_ !== 1'b1) begin
            n_bad++;
            $display("FAIL late_rdy_after: rdy0 %b g0 %b expected 1 1", m0_rdy_, m0_grnt_);
        end
        rom_rdy_ = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_round_robin();
        test_burst_limit();
        test_nonowner_as();
        test_slow_rom();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
